load_replay_buffer: RTL and testbench



---
 rtl/load_replay_buffer_pkg.sv | 59 +++++
 rtl/load_replay_select.sv | 22 ++
 rtl/load_replay_buffer.sv | 143 ++++++++++++++
 tb/tb_load_replay_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_replay_buffer_pkg.sv
// load_replay_buffer_pkg: shared types, sizes and helpers for the load replay buffer
// Contents: ReplayReason enum, RobIdx/StoreIdx age tags, LoadReplayEntry record,
// LOAD_REPLAY_SIZE, the wake-event matcher and the rob-age comparator.
package load_replay_buffer_pkg;
    localparam int LOAD_PIPELINE         = 2;
    localparam int LOAD_REPLAY_SIZE      = 8;
    localparam int LOAD_ISSUE_BANK_WIDTH = 4;
    localparam int MSHR_WIDTH            = 3;
    localparam int ROB_IDX_WIDTH         = 6;
    localparam int STORE_IDX_WIDTH       = 4;
    localparam int BANK_WIDTH            = (LOAD_PIPELINE > 1) ? $clog2(LOAD_PIPELINE) : 1;

    typedef enum logic [1:0] {
        MISS     = 2'd0,
        STDATA   = 2'd1,
        MSHRFULL = 2'd2
    } ReplayReason;

    typedef struct packed {
        logic                     dir;
        logic [ROB_IDX_WIDTH-1:0] idx;
    } RobIdx;

    typedef struct packed {
        logic                       dir;
        logic [STORE_IDX_WIDTH-1:0] idx;
    } StoreIdx;

    typedef struct packed {
        logic                             valid;
        logic                             wake;
        logic [BANK_WIDTH-1:0]            bank;
        logic [LOAD_ISSUE_BANK_WIDTH-1:0] issue_idx;
        RobIdx                            rob_idx;
        ReplayReason                      reason;
        logic [MSHR_WIDTH-1:0]            mshr_idx;
        StoreIdx                          sq_idx;
    } LoadReplayEntry;

    function automatic logic replay_wake(
        ReplayReason           reason,
        logic [MSHR_WIDTH-1:0] mshr_idx,
        StoreIdx               sq_idx,
        logic                  refill_en,
        logic [MSHR_WIDTH-1:0] refill_mshr,
        logic                  stdata_en,
        StoreIdx               stdata_sq,
        logic                  mshr_free
    );
        return (reason == MISS && refill_en && mshr_idx == refill_mshr) ||
               (reason == STDATA && stdata_en && sq_idx == stdata_sq) ||
               (reason == MSHRFULL && mshr_free);
    endfunction

    // Wrap bit flips the sense of the index compare when the two tags straddle a ROB wrap.
    function automatic logic is_older(RobIdx rob, RobIdx redirect);
        return (rob.dir ^ redirect.dir) ^ (redirect.idx > rob.idx);
    endfunction
endpackage

// File: rtl/load_replay_select.sv
// load_replay_select: lowest-index picker over one bank's ready replay entries
// Ports: i_req (ready mask), o_grant (one-hot lowest request), o_idx (its index), o_valid (any request).
module load_replay_select
    import load_replay_buffer_pkg::*;
#(
    parameter int DEPTH = LOAD_REPLAY_SIZE,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);
    assign o_grant = i_req & (~i_req + DEPTH'(1));
    assign o_valid = |i_req;

    always_comb begin
        o_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (i_req[i]) o_idx = PTR_W'(i);
    end
endmodule

// File: rtl/load_replay_buffer.sv
// load_replay_buffer: parks slow-failed loads and re-arms their issue-bank entries once unblocked
// Ports: clk/rst (sync, active-high); i_fail_* per pipeline (stage-2 slow failure);
// i_refill_*, i_stdata_*, i_mshr_free (wake events); i_redirect/i_redirect_idx (flush);
// o_reply_slow per bank {en, issue_idx} (registered); o_full (free entries < PIPELINE).
// Build option LOAD_REPLAY_TIMEOUT_EN: per-entry 6-bit wait counter forces wake at 63.
module load_replay_buffer
    import load_replay_buffer_pkg::*;
#(
    parameter int PIPELINE = LOAD_PIPELINE,
    parameter int DEPTH    = LOAD_REPLAY_SIZE,
    parameter int IDX_W    = LOAD_ISSUE_BANK_WIDTH,
    parameter int MSHR_W   = MSHR_WIDTH,
    localparam int ROB_W   = $bits(RobIdx),
    localparam int SQ_W    = $bits(StoreIdx),
    localparam int RPW     = 1 + IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIPELINE-1:0]       i_fail_en,
    input  logic [PIPELINE*IDX_W-1:0] i_fail_issue_idx,
    input  logic [PIPELINE*ROB_W-1:0] i_fail_rob_idx,
    input  logic [PIPELINE*2-1:0]     i_fail_reason,
    input  logic [PIPELINE*MSHR_W-1:0] i_fail_mshr_idx,
    input  logic [PIPELINE*SQ_W-1:0]  i_fail_sq_idx,
    input  logic                      i_refill_en,
    input  logic [MSHR_W-1:0]         i_refill_mshr_idx,
    input  logic                      i_stdata_en,
    input  logic [SQ_W-1:0]           i_stdata_sq_idx,
    input  logic                      i_mshr_free,
    input  logic                      i_redirect,
    input  logic [ROB_W-1:0]          i_redirect_idx,
    output logic [PIPELINE*RPW-1:0]   o_reply_slow,
    output logic                      o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    LoadReplayEntry            r_ent [DEPTH];
    logic [PIPELINE*RPW-1:0]   r_reply;
    logic [DEPTH-1:0]          w_taken, w_hit, w_keep, w_rel, w_tmo;
    logic [PIPELINE-1:0]       w_alloc, w_sel_vld;
    logic [PTR_W-1:0]          w_alloc_idx [PIPELINE];
    logic [PTR_W-1:0]          w_sel_idx [PIPELINE];
    logic [DEPTH-1:0]          w_req [PIPELINE];
    logic [DEPTH-1:0]          w_grant [PIPELINE];
    LoadReplayEntry            w_new [PIPELINE];
    logic [CNT_W-1:0]          w_cnt;

    always_comb begin
        w_taken = '0;
        w_alloc = '0;
        w_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt    = w_cnt + CNT_W'(r_ent[i].valid);
            w_hit[i] = r_ent[i].valid && replay_wake(r_ent[i].reason, r_ent[i].mshr_idx, r_ent[i].sq_idx,
                           i_refill_en, i_refill_mshr_idx, i_stdata_en, i_stdata_sq_idx, i_mshr_free);
            w_keep[i] = !i_redirect || is_older(r_ent[i].rob_idx, i_redirect_idx);
        end
        // Slots freed this cycle are still valid here, so they only become allocatable next cycle.
        for (int p = 0; p < PIPELINE; p++) begin
            w_alloc_idx[p] = '0;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (!r_ent[i].valid && !w_taken[i]) begin
                    w_alloc[p]     = i_fail_en[p] && !i_redirect;
                    w_alloc_idx[p] = PTR_W'(i);
                end
            if (w_alloc[p]) w_taken[w_alloc_idx[p]] = 1'b1;
            w_new[p]           = '0;
            w_new[p].valid     = 1'b1;
            w_new[p].bank      = BANK_WIDTH'(p);
            w_new[p].issue_idx = i_fail_issue_idx[p*IDX_W +: IDX_W];
            w_new[p].rob_idx   = i_fail_rob_idx[p*ROB_W +: ROB_W];
            w_new[p].reason    = ReplayReason'(i_fail_reason[p*2 +: 2]);
            w_new[p].mshr_idx  = i_fail_mshr_idx[p*MSHR_W +: MSHR_W];
            w_new[p].sq_idx    = i_fail_sq_idx[p*SQ_W +: SQ_W];
            w_new[p].wake      = replay_wake(w_new[p].reason, w_new[p].mshr_idx, w_new[p].sq_idx,
                                     i_refill_en, i_refill_mshr_idx, i_stdata_en, i_stdata_sq_idx, i_mshr_free);
        end
    end

    always_comb begin
        for (int p = 0; p < PIPELINE; p++) begin
            w_req[p] = '0;
            for (int i = 0; i < DEPTH; i++)
                w_req[p][i] = r_ent[i].valid && r_ent[i].wake && r_ent[i].bank == BANK_WIDTH'(p);
        end
    end

    for (genvar g = 0; g < PIPELINE; g++) begin : g_sel
        load_replay_select #(.DEPTH(DEPTH)) u_sel (
            .i_req   (w_req[g]),
            .o_grant (w_grant[g]),
            .o_idx   (w_sel_idx[g]),
            .o_valid (w_sel_vld[g])
        );
    end

    always_comb begin
        w_rel = '0;
        for (int p = 0; p < PIPELINE; p++) w_rel = w_rel | w_grant[p];
    end

`ifdef LOAD_REPLAY_TIMEOUT_EN
    logic [5:0] r_wait [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_tmo[i] = r_ent[i].valid && !r_ent[i].wake && r_wait[i] == 6'd63;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            r_wait[i] <= (rst || w_taken[i]) ? 6'd0 :
                         (r_ent[i].valid && !r_ent[i].wake) ? r_wait[i] + 6'd1 : r_wait[i];
    end
`else
    assign w_tmo = '0;
`endif

    // A redirect cycle neither releases nor replies, so a selected survivor is retried afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_reply <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (!w_keep[i] || (w_rel[i] && !i_redirect)) r_ent[i].valid <= 1'b0;
                else if (w_hit[i] || w_tmo[i]) r_ent[i].wake <= 1'b1;
            for (int p = 0; p < PIPELINE; p++) begin
                if (w_alloc[p]) r_ent[w_alloc_idx[p]] <= w_new[p];
                r_reply[p*RPW +: RPW] <= i_redirect ? '0 : {w_sel_vld[p], r_ent[w_sel_idx[p]].issue_idx};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && o_full)
            assert (i_fail_en == '0) else $error("load_replay_buffer: fail_en asserted while full");
    end

    assign o_reply_slow = r_reply;
    assign o_full       = (DEPTH - int'(w_cnt)) < PIPELINE;
endmodule

// File: tb/tb_load_replay_buffer.sv
// tb_load_replay_buffer: directed stimulus with a per-bank reply scoreboard for load_replay_buffer
module tb_load_replay_buffer;
    import load_replay_buffer_pkg::*;

    localparam int P   = LOAD_PIPELINE;
    localparam int IW  = LOAD_ISSUE_BANK_WIDTH;
    localparam int MW  = MSHR_WIDTH;
    localparam int RW  = $bits(RobIdx);
    localparam int SW  = $bits(StoreIdx);
    localparam int RPW = 1 + IW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [P-1:0]      i_fail_en;
    logic [P*IW-1:0]   i_fail_issue_idx;
    logic [P*RW-1:0]   i_fail_rob_idx;
    logic [P*2-1:0]    i_fail_reason;
    logic [P*MW-1:0]   i_fail_mshr_idx;
    logic [P*SW-1:0]   i_fail_sq_idx;
    logic              i_refill_en;
    logic [MW-1:0]     i_refill_mshr_idx;
    logic              i_stdata_en;
    logic [SW-1:0]     i_stdata_sq_idx;
    logic              i_mshr_free;
    logic              i_redirect;
    logic [RW-1:0]     i_redirect_idx;
    logic [P*RPW-1:0]  o_reply_slow;
    logic              o_full;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_replay_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .i_fail_en         (i_fail_en),
        .i_fail_issue_idx  (i_fail_issue_idx),
        .i_fail_rob_idx    (i_fail_rob_idx),
        .i_fail_reason     (i_fail_reason),
        .i_fail_mshr_idx   (i_fail_mshr_idx),
        .i_fail_sq_idx     (i_fail_sq_idx),
        .i_refill_en       (i_refill_en),
        .i_refill_mshr_idx (i_refill_mshr_idx),
        .i_stdata_en       (i_stdata_en),
        .i_stdata_sq_idx   (i_stdata_sq_idx),
        .i_mshr_free       (i_mshr_free),
        .i_redirect        (i_redirect),
        .i_redirect_idx    (i_redirect_idx),
        .o_reply_slow      (o_reply_slow),
        .o_full            (o_full)
    );

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        i_fail_en         = '0;
        i_fail_issue_idx  = '0;
        i_fail_rob_idx    = '0;
        i_fail_reason     = '0;
        i_fail_mshr_idx   = '0;
        i_fail_sq_idx     = '0;
        i_refill_en       = 1'b0;
        i_refill_mshr_idx = '0;
        i_stdata_en       = 1'b0;
        i_stdata_sq_idx   = '0;
        i_mshr_free       = 1'b0;
        i_redirect        = 1'b0;
        i_redirect_idx    = '0;
    endtask

    task automatic fail(int p, int issue, logic dir, int rob, ReplayReason rs, int mshr, int sq);
        i_fail_en[p]                   = 1'b1;
        i_fail_issue_idx[p*IW +: IW]   = IW'(issue);
        i_fail_rob_idx[p*RW +: RW]     = {dir, ROB_IDX_WIDTH'(rob)};
        i_fail_reason[p*2 +: 2]        = rs;
        i_fail_mshr_idx[p*MW +: MW]    = MW'(mshr);
        i_fail_sq_idx[p*SW +: SW]      = SW'(sq);
    endtask

    task automatic expect_reply(int p, int idx, int at);
        exp_t e;
        e.idx = idx;
        e.cyc = at;
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor: every reply pulse must match the oldest outstanding expectation for its bank.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < P; p++) begin
                if (o_reply_slow[p*RPW + IW]) begin
                    exp_t e;
                    int   pending;
                    pending = (p == 0) ? q0.size() : q1.size();
                    if (pending == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_reply bank%0d: got idx %0d at cycle %0d, required no reply",
                                 p, o_reply_slow[p*RPW +: IW], cyc);
                    end else begin
                        if (p == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check($sformatf("reply%0d_idx", p), int'(o_reply_slow[p*RPW +: IW]), e.idx);
                        check($sformatf("reply%0d_cycle", p), cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset_full", int'(o_full), 0);
        check("reset_reply", int'(o_reply_slow), 0);
        tick(2);

        // MISS, refill arrives five cycles later
        fail(0, 3, 1'b0, 1, MISS, 2, 0);
        tick();
        idle();
        tick(4);
        i_refill_en       = 1'b1;
        i_refill_mshr_idx = 3'd2;
        expect_reply(0, 3, cyc + 2);
        tick();
        idle();
        tick(4);

        // STDATA with store data written in the same cycle: bypass wake
        fail(1, 5, 1'b0, 2, STDATA, 0, 7);
        i_stdata_en     = 1'b1;
        i_stdata_sq_idx = SW'(7);
        expect_reply(1, 5, cyc + 2);
        tick();
        idle();
        tick(3);

        // MSHRFULL on both pipelines, released together
        fail(0, 1, 1'b0, 3, MSHRFULL, 0, 0);
        fail(1, 2, 1'b0, 4, MSHRFULL, 0, 0);
        tick();
        idle();
        tick(2);
        i_mshr_free = 1'b1;
        expect_reply(0, 1, cyc + 2);
        expect_reply(1, 2, cyc + 2);
        tick();
        idle();
        tick(3);

        // Fill to the full threshold, then release one entry
        for (int i = 0; i < 7; i++) begin
            fail(0, i, 1'b0, 20 + i, MISS, i, 0);
            tick();
            if (i == 5) check("full_at_6", int'(o_full), 0);
        end
        idle();
        check("full_at_7", int'(o_full), 1);
        i_refill_en       = 1'b1;
        i_refill_mshr_idx = 3'd0;
        expect_reply(0, 0, cyc + 2);
        tick();
        idle();
        check("full_while_woken", int'(o_full), 1);
        tick();
        check("full_after_release", int'(o_full), 0);
        i_redirect     = 1'b1;
        i_redirect_idx = '0;
        tick();
        idle();
        tick(2);
        check("empty_after_flush", int'(o_full), 0);

        // Redirect at rob 9: rob 5 and a wrapped-older rob survive, 9 and 12 flush; wake same cycle
        fail(0, 4, 1'b0, 5, MSHRFULL, 0, 0);
        fail(1, 6, 1'b0, 9, MSHRFULL, 0, 0);
        tick();
        idle();
        fail(0, 7, 1'b0, 12, MSHRFULL, 0, 0);
        fail(1, 8, 1'b1, 30, MSHRFULL, 0, 0);
        tick();
        idle();
        tick();
        i_redirect     = 1'b1;
        i_redirect_idx = {1'b0, ROB_IDX_WIDTH'(9)};
        i_mshr_free    = 1'b1;
        expect_reply(0, 4, cyc + 2);
        expect_reply(1, 8, cyc + 2);
        tick();
        idle();
        check("redirect_reply_zero", int'(o_reply_slow), 0);
        tick(4);

        // MISS that is never refilled
        fail(0, 9, 1'b0, 40, MISS, 5, 0);
`ifdef LOAD_REPLAY_TIMEOUT_EN
        expect_reply(0, 9, cyc + 66);
`endif
        tick();
        idle();
        tick(70);

        check("pending_bank0", q0.size(), 0);
        check("pending_bank1", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
